// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: bus widths and the CPU read-FSM states.
package fb_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fb_port_arbiter_wfifo.sv
// Write buffer for CPU framebuffer writes: a plain synchronous FIFO of {addr,data}.
// Arbitration lives in the parent; this block only stores and orders entries.
module fb_wfifo #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 16,
  parameter  int DW    = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [AW+DW-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Pointers are exactly PW bits wide, so wrap-around is the natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = {push_addr, push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign {head_addr, head_data} = mem_q[rd_ptr_q];
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates the single-port framebuffer RAM between VGA scan-out (top priority),
// a single-outstanding CPU read and the buffered CPU write stream.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter  int ADDR_W      = FB_ADDR_W,
  parameter  int DATA_W      = FB_DATA_W,
  parameter  int WFIFO_DEPTH = 4,
  localparam int LVL_W       = $clog2(WFIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_rd_valid,
  output logic              cpu_rd_ready,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic              cpu_rd_data_valid,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LVL_W-1:0]  wfifo_level
);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic              vga_pend_q, vga_pend_d;
  logic              rdy_en_q, rdy_en_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] fifo_head_addr;
  logic [DATA_W-1:0] fifo_head_data;
  logic              grant_rd;

  fb_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_wfifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_addr (cpu_wr_addr),
    .push_data (cpu_wr_data),
    .pop       (fifo_pop),
    .head_addr (fifo_head_addr),
    .head_data (fifo_head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (wfifo_level)
  );

  // Readies stay low through reset and for the release cycle itself.
  always_comb begin
    cpu_rd_ready = rst_n && rdy_en_q && (state_q == IDLE);
    cpu_wr_ready = rst_n && rdy_en_q && !fifo_full &&
                   (state_q != RD_PEND) && (state_q != RD_DATA);
    fifo_push    = cpu_wr_valid && cpu_wr_ready;
  end

  // A pending read only wins once the FIFO is empty, keeping it behind earlier writes.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    grant_rd  = 1'b0;
    fifo_pop  = 1'b0;
    if (rst_n) begin
      if (vga_req) begin
        mem_en   = 1'b1;
        mem_addr = vga_addr;
      end else if ((state_q == RD_PEND) && fifo_empty) begin
        mem_en   = 1'b1;
        mem_addr = rd_addr_q;
        grant_rd = 1'b1;
      end else if (!fifo_empty) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_head_addr;
        mem_wdata = fifo_head_data;
        fifo_pop  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    rd_addr_d         = rd_addr_q;
    rd_data_d         = rd_data_q;
    cpu_rd_data_valid = 1'b0;
    cpu_rd_data       = rd_data_q;
    case (state_q)
      IDLE: begin
        if (cpu_rd_valid && cpu_rd_ready) begin
          rd_addr_d = cpu_rd_addr;
          state_d   = RD_PEND;
        end
      end
      RD_PEND: begin
        if (grant_rd) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        cpu_rd_data_valid = rst_n;
        cpu_rd_data       = mem_rdata;
        rd_data_d         = mem_rdata;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vga_pend_d = vga_req;
    vga_data_d = vga_pend_q ? mem_rdata : vga_data_q;
    rdy_en_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      vga_data_q <= '0;
      vga_pend_q <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      vga_data_q <= vga_data_d;
      vga_pend_q <= vga_pend_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

  assign vga_data = vga_data_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed scenarios plus a randomized
// run, all compared every cycle against a queue-based framebuffer model.
module tb_fb_port_arbiter;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_req = 1'b0;
  logic [15:0] vga_addr = '0;
  logic [7:0]  vga_data;
  logic        cpu_wr_valid = 1'b0;
  logic        cpu_wr_ready;
  logic [15:0] cpu_wr_addr = '0;
  logic [7:0]  cpu_wr_data = '0;
  logic        cpu_rd_valid = 1'b0;
  logic        cpu_rd_ready;
  logic [15:0] cpu_rd_addr = '0;
  logic        cpu_rd_data_valid;
  logic [7:0]  cpu_rd_data;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [2:0]  wfifo_level;

  int vectors = 0;
  int miscompares = 0;

  fb_port_arbiter #(
    .ADDR_W      (16),
    .DATA_W      (8),
    .WFIFO_DEPTH (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .vga_req           (vga_req),
    .vga_addr          (vga_addr),
    .vga_data          (vga_data),
    .cpu_wr_valid      (cpu_wr_valid),
    .cpu_wr_ready      (cpu_wr_ready),
    .cpu_wr_addr       (cpu_wr_addr),
    .cpu_wr_data       (cpu_wr_data),
    .cpu_rd_valid      (cpu_rd_valid),
    .cpu_rd_ready      (cpu_rd_ready),
    .cpu_rd_addr       (cpu_rd_addr),
    .cpu_rd_data_valid (cpu_rd_data_valid),
    .cpu_rd_data       (cpu_rd_data),
    .mem_en            (mem_en),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .wfifo_level       (wfifo_level)
  );

  always #5 clk = ~clk;

  // Power-on framebuffer contents; 0x0102 holds the known VGA test pixel.
  function automatic logic [7:0] init_val(logic [15:0] a);
    if (a == 16'h0102) return 8'hA5;
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction

  // Behavioural single-port BRAM with one-cycle read latency.
  logic [7:0] ram [0:65535];
  bit         ram_written [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]         <= mem_wdata;
        ram_written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // Reference model: committed contents, pending writes, one outstanding read.
  logic [7:0]  shadow [logic [15:0]];
  wr_t         pend[$];
  int          rd_st = 0;
  logic [15:0] rd_a = '0;
  logic [7:0]  rd_exp = '0;
  logic [7:0]  held = '0;
  logic [7:0]  exp_vga = '0;
  logic        pv1_v = 1'b0, pv2_v = 1'b0;
  logic [15:0] pv1_a = '0, pv2_a = '0;
  logic        rdy_en = 1'b0;
  logic        live = 1'b0;

  function automatic logic [7:0] exp_mem(logic [15:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  function automatic logic [7:0] exp_read(logic [15:0] a);
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].a == a) return pend[i].d;
    end
    return exp_mem(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_check();
    logic exp_wr_rdy, exp_rd_rdy;
    if (!live) return;
    exp_wr_rdy = rst_n && rdy_en && (pend.size() < 4) && (rd_st == 0);
    exp_rd_rdy = rst_n && rdy_en && (rd_st == 0);
    checkOutput("wr_ready", 32'(cpu_wr_ready), 32'(exp_wr_rdy));
    checkOutput("rd_ready", 32'(cpu_rd_ready), 32'(exp_rd_rdy));
    checkOutput("rd_valid", 32'(cpu_rd_data_valid), 32'(rst_n && (rd_st == 2)));
    checkOutput("rd_data", 32'(cpu_rd_data), 32'((rd_st == 2) ? rd_exp : held));
    checkOutput("level", 32'(wfifo_level), 32'(pend.size()));
    checkOutput("vga_data", 32'(vga_data), 32'(exp_vga));
    if (!rst_n) begin
      checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    end else if (vga_req) begin
      checkOutput("vga_grant", {mem_addr, 6'd0, mem_en, mem_we}, {vga_addr, 8'b10});
    end else if ((rd_st == 1) && (pend.size() == 0)) begin
      checkOutput("rd_grant", {mem_addr, 6'd0, mem_en, mem_we}, {rd_a, 8'b10});
    end else if (pend.size() > 0) begin
      checkOutput("wr_grant", {mem_addr, mem_wdata, mem_en, mem_we}, {pend[0].a, pend[0].d, 2'b11});
    end else begin
      checkOutput("no_grant", 32'(mem_en), 32'd0);
    end
  endtask

  task automatic model_commit();
    logic wr_hs, rd_hs, issue, pop_ok;
    if (!rst_n) begin
      pend.delete();
      rd_st   = 0;
      held    = '0;
      exp_vga = '0;
      pv1_v   = 1'b0;
      pv2_v   = 1'b0;
      rdy_en  = 1'b0;
      live    = 1'b1;
      return;
    end
    wr_hs  = cpu_wr_valid && rdy_en && (pend.size() < 4) && (rd_st == 0);
    rd_hs  = cpu_rd_valid && rdy_en && (rd_st == 0);
    issue  = !vga_req && (rd_st == 1) && (pend.size() == 0);
    pop_ok = !vga_req && (pend.size() > 0);
    if (pop_ok) begin
      shadow[pend[0].a] = pend[0].d;
      void'(pend.pop_front());
    end
    if (wr_hs) pend.push_back('{cpu_wr_addr, cpu_wr_data});
    case (rd_st)
      2: begin
        held  = rd_exp;
        rd_st = 0;
      end
      1: if (issue) rd_st = 2;
      default: if (rd_hs) begin
        rd_a   = cpu_rd_addr;
        rd_exp = exp_read(cpu_rd_addr);
        rd_st  = 1;
      end
    endcase
    rdy_en = 1'b1;
    pv2_v  = pv1_v;
    pv2_a  = pv1_a;
    pv1_v  = vga_req;
    pv1_a  = vga_addr;
    if (pv2_v) exp_vga = exp_mem(pv2_a);
  endtask

  // One clock cycle: drive after the falling edge, settle, check, advance the model.
  task automatic applyStimulus(input logic r, input logic vr, input logic [15:0] va,
                               input logic w, input logic [15:0] wa, input logic [7:0] wd,
                               input logic rr, input logic [15:0] ra);
    @(negedge clk);
    rst_n        = r;
    vga_req      = vr;
    vga_addr     = va;
    cpu_wr_valid = w;
    cpu_wr_addr  = wa;
    cpu_wr_data  = wd;
    cpu_rd_valid = rr;
    cpu_rd_addr  = ra;
    #1;
    model_check();
    model_commit();
  endtask

  task automatic idle(input logic vr, input logic [15:0] va);
    applyStimulus(1'b1, vr, va, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
  endtask

  initial begin
    $display("[TB] reset with valids high");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h8000, 1'b1, 16'h0001, 8'h11, 1'b1, 16'h0001);
    end
    checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset_wr_ready", 32'(cpu_wr_ready), 32'd0);
    checkOutput("reset_rd_ready", 32'(cpu_rd_ready), 32'd0);
    checkOutput("reset_vga_data", 32'(vga_data), 32'd0);
    checkOutput("reset_rd_data", 32'(cpu_rd_data), 32'd0);
    checkOutput("reset_rd_valid", 32'(cpu_rd_data_valid), 32'd0);
    checkOutput("reset_level", 32'(wfifo_level), 32'd0);
    idle(1'b0, 16'h0);
    idle(1'b0, 16'h0);
    checkOutput("release_wr_ready", 32'(cpu_wr_ready), 32'd1);
    checkOutput("release_rd_ready", 32'(cpu_rd_ready), 32'd1);

    $display("[TB] VGA read latency");
    idle(1'b1, 16'h0102);
    checkOutput("vga_issue", {mem_addr, 6'd0, mem_en, mem_we}, {16'h0102, 8'b10});
    idle(1'b0, 16'h0);
    checkOutput("vga_no_we", 32'(mem_we), 32'd0);
    idle(1'b0, 16'h0);
    checkOutput("vga_data_n2", 32'(vga_data), 32'hA5);

    $display("[TB] buffered writes under VGA load");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h8000 + 16'(i), 1'b1, 16'h0020 + 16'(i), 8'h50 + 8'(i), 1'b0, 16'h0);
      checkOutput("fill_ready", 32'(cpu_wr_ready), (i < 4) ? 32'd1 : 32'd0);
      checkOutput("fill_level", 32'(wfifo_level), 32'(i));
    end
    idle(1'b1, 16'h8005);
    checkOutput("full_level", 32'(wfifo_level), 32'd4);
    for (int j = 0; j < 5; j++) begin
      idle(1'b0, 16'h0);
      checkOutput("drain_level", 32'(wfifo_level), 32'(4 - j));
      if (j < 4) begin
        checkOutput("drain_pop", {mem_addr, mem_wdata, 6'd0, mem_en, mem_we},
                    {16'h0020 + 16'(j), 8'h50 + 8'(j), 8'b11});
      end else begin
        checkOutput("drain_done", 32'(mem_en), 32'd0);
      end
    end

    $display("[TB] read-after-write in one cycle");
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'h0010, 8'h3C, 1'b1, 16'h0010);
    checkOutput("raw_both_ready", {cpu_wr_ready, cpu_rd_ready}, 32'b11);
    idle(1'b0, 16'h0);
    checkOutput("raw_write_first", {mem_addr, mem_wdata, 6'd0, mem_en, mem_we}, {16'h0010, 8'h3C, 8'b11});
    checkOutput("raw_wr_blocked", 32'(cpu_wr_ready), 32'd0);
    idle(1'b0, 16'h0);
    checkOutput("raw_read_issue", {mem_addr, 6'd0, mem_en, mem_we}, {16'h0010, 8'b10});
    idle(1'b0, 16'h0);
    checkOutput("raw_valid", {cpu_rd_data_valid, cpu_rd_data}, {1'b1, 8'h3C});
    idle(1'b0, 16'h0);
    checkOutput("raw_hold", {cpu_rd_data_valid, cpu_rd_data}, {1'b0, 8'h3C});

    $display("[TB] read under VGA contention");
    applyStimulus(1'b1, 1'b1, 16'h9000, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0021);
    idle(1'b1, 16'h9001);
    checkOutput("cont_vga_wins", {mem_addr, 6'd0, mem_en, mem_we}, {16'h9001, 8'b10});
    idle(1'b0, 16'h0);
    checkOutput("cont_read_issue", {mem_addr, 6'd0, mem_en, mem_we}, {16'h0021, 8'b10});
    idle(1'b1, 16'h9003);
    checkOutput("cont_valid", {cpu_rd_data_valid, cpu_rd_data}, {1'b1, 8'h51});
    idle(1'b0, 16'h0);
    checkOutput("cont_vga_data", 32'(vga_data), 32'(init_val(16'h9001)));
    idle(1'b0, 16'h0);
    checkOutput("cont_vga_data2", 32'(vga_data), 32'(init_val(16'h9003)));

    $display("[TB] reset while a read is pending");
    applyStimulus(1'b1, 1'b1, 16'hA000, 1'b1, 16'h0030, 8'h77, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'hA001, 1'b1, 16'h0031, 8'h78, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'hA002, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0030);
    idle(1'b1, 16'hA003);
    checkOutput("pend_level", 32'(wfifo_level), 32'd2);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 16'hA004, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
      checkOutput("rst_no_valid", 32'(cpu_rd_data_valid), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 16'h0);
      checkOutput("post_rst_no_valid", 32'(cpu_rd_data_valid), 32'd0);
      checkOutput("post_rst_level", 32'(wfifo_level), 32'd0);
      checkOutput("post_rst_no_drain", 32'(mem_en), 32'd0);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      int pv;
      pv = (((i / 60) % 2) == 0) ? 85 : 25;
      applyStimulus((i % 500) != 499,
                    ($urandom % 100) < 32'(pv), {1'b1, 15'($urandom)},
                    ($urandom % 100) < 45, 16'h0040 + 16'($urandom % 16), 8'($urandom),
                    ($urandom % 100) < 30, 16'h0040 + 16'($urandom % 16));
    end
    for (int i = 0; i < 20; i++) idle(1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
